// File: rtl/bf16_cvt_pkg.sv
// Shared types for the FP32->BF16 converter arbiter: exception flags, FSM states,
// and the canonical BF16 quiet NaN.
package bf16_cvt_pkg;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } cvt_flags_t;

  typedef enum logic [1:0] {STOPPED, RUN, DRAIN} cvt_arb_state_t;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

endpackage

// File: rtl/fp32_bf16_cvt_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp32_to_bf16.sv
// Combinational FP32->BF16 conversion, round-to-nearest-even. Overflow and underflow
// are reported in place of inexact; any NaN collapses to BF16_QNAN with invalid set.
module fp32_to_bf16
  import bf16_cvt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  output logic [15:0] y,
  output cvt_flags_t  flags
);

  logic        unused_clk_rst;
  logic        guard, sticky, round_up, lost, tiny, exp_max;
  logic [15:0] rounded;

  assign unused_clk_rst = clk ^ reset;

  assign exp_max  = &a[30:23];
  assign tiny     = (a[30:23] == 8'h00);
  assign guard    = a[15];
  assign sticky   = |a[14:0];
  assign lost     = guard | sticky;
  assign round_up = guard & (sticky | a[16]);
  // Mantissa carry ripples into the exponent; a finite max can never wrap past inf.
  assign rounded  = a[31:16] + {15'd0, round_up};

  always_comb begin
    y     = rounded;
    flags = '0;
    if (exp_max) begin
      if (|a[22:0]) begin
        y             = BF16_QNAN;
        flags.invalid = 1'b1;
      end else begin
        y = a[31:16];
      end
    end else begin
      flags.overflow  = &rounded[14:7];
      flags.underflow = tiny & lost & ~(&rounded[14:7]);
      flags.inexact   = lost & ~tiny & ~(&rounded[14:7]);
    end
  end

endmodule

// File: rtl/fp32_bf16_cvt_arbiter.sv
// Round-robin sharing of one fp32_to_bf16 converter with a registered valid/ready
// response. Optional CVT_STICKY_FLAGS_EN adds an OR-accumulated flag register.
module fp32_bf16_cvt_arbiter
  import bf16_cvt_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output cvt_flags_t              rsp_flags,
`ifdef CVT_STICKY_FLAGS_EN
  output cvt_flags_t              sticky_flags,
  input  logic                    flags_clear,
`endif
  output logic                    stopped
);

  cvt_arb_state_t     state_q, state_d;
  logic [ID_W-1:0]    ptr, gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_req, slot_free, accept;
  logic [15:0]        cvt_y;
  cvt_flags_t         cvt_flags;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid), .ptr(ptr), .grant(grant), .idx(gnt_idx), .any(any_req)
  );

  fp32_to_bf16 u_cvt (
    .clk(clk), .reset(reset), .a(req_data[gnt_idx]), .y(cvt_y), .flags(cvt_flags)
  );

  assign slot_free = ~rsp_valid | rsp_ready;
  // en gates accept directly so the RUN->DRAIN cycle never takes new work.
  assign accept    = (state_q == RUN) & en & slot_free & any_req;
  assign req_ready = accept ? grant : '0;
  assign stopped   = (state_q == STOPPED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if (en) state_d = RUN;
               else if (slot_free) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= STOPPED;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_flags <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cvt_y;
        rsp_id    <= gnt_idx;
        rsp_flags <= cvt_flags;
        ptr       <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef CVT_STICKY_FLAGS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           sticky_flags <= '0;
    else if (flags_clear) sticky_flags <= rsp_hs ? rsp_flags : '0;
    else if (rsp_hs)      sticky_flags <= sticky_flags | rsp_flags;
  end
`endif

endmodule

// File: tb/tb_fp32_bf16_cvt_arbiter.sv
// Directed bench for fp32_bf16_cvt_arbiter; sticky-flag checks follow CVT_STICKY_FLAGS_EN.
module tb_fp32_bf16_cvt_arbiter;

  logic             clk = 1'b0;
  logic             reset, en, rsp_ready, flags_clear;
  logic [3:0]       req_valid, req_ready;
  logic [3:0][31:0] req_data;
  logic             rsp_valid, stopped;
  logic [15:0]      rsp_data;
  logic [1:0]       rsp_id;
  logic [3:0]       rsp_flags, sticky_flags;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  fp32_bf16_cvt_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_flags(rsp_flags),
`ifdef CVT_STICKY_FLAGS_EN
    .sticky_flags(sticky_flags), .flags_clear(flags_clear),
`endif
    .stopped(stopped)
  );

`ifndef CVT_STICKY_FLAGS_EN
  assign sticky_flags = 4'b0000;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; rsp_ready = 1'b0; flags_clear = 1'b0;
    req_valid = '0; req_data = '0;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_flags !== 4'b0) begin failures++; $display("FAIL reset_rsp_flags got=%b exp=0000", rsp_flags); end
    checks++; if (stopped !== 1'b1) begin failures++; $display("FAIL reset_stopped got=%b exp=1", stopped); end
    checks++; if (sticky_flags !== 4'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0000", sticky_flags); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (stopped !== 1'b1) begin failures++; $display("FAIL stopped_hold got=%b exp=1", stopped); end
  endtask

  task automatic send(input int i, input logic [31:0] d, input logic [15:0] ed,
                      input logic [3:0] ef, input string nm);
    req_valid = 4'(1 << i);
    req_data[i] = d;
    #1;
    checks++; if (req_ready !== 4'(1 << i)) begin failures++; $display("FAIL %s_req_ready got=%b exp=%b", nm, req_ready, 4'(1 << i)); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", nm, rsp_valid); end
    checks++; if (rsp_data !== ed) begin failures++; $display("FAIL %s_data got=%h exp=%h", nm, rsp_data, ed); end
    checks++; if (rsp_id !== 2'(i)) begin failures++; $display("FAIL %s_id got=%0d exp=%0d", nm, rsp_id, i); end
    checks++; if (rsp_flags !== ef) begin failures++; $display("FAIL %s_flags got=%b exp=%b", nm, rsp_flags, ef); end
  endtask

  task automatic test_convert();
    en = 1'b1; rsp_ready = 1'b1;
    tick();
    checks++; if (stopped !== 1'b0) begin failures++; $display("FAIL run_stopped got=%b exp=0", stopped); end
    send(0, 32'h3F800000, 16'h3F80, 4'b0000, "one");
    send(1, 32'h3F800001, 16'h3F80, 4'b0001, "inexact");
    send(2, 32'h7FC00001, 16'h7FC0, 4'b1000, "nan");
    send(3, 32'h7F7FFFFF, 16'h7F80, 4'b0100, "overflow");
  endtask

  task automatic test_rounding();
    send(0, 32'h00000001, 16'h0000, 4'b0010, "underflow");
    send(1, 32'h3F808000, 16'h3F80, 4'b0001, "tie_even_down");
    send(2, 32'h3F818000, 16'h3F82, 4'b0001, "tie_odd_up");
    send(3, 32'hFF800000, 16'hFF80, 4'b0000, "neg_inf");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) req_data[i] = 32'h40000000 | (32'(i) << 16);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL b2b_first_grant got=%b exp=0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== 16'h4000 + 16'(k % 4))
        begin failures++; $display("FAIL b2b_%0d got=v%b id%0d %h exp=v1 id%0d %h", k, rsp_valid, rsp_id, rsp_data, k % 4, 16'h4000 + 16'(k % 4)); end
      checks++; if (req_ready !== 4'(1 << ((k + 1) % 4))) begin failures++; $display("FAIL b2b_grant_%0d got=%b exp=%b", k, req_ready, 4'(1 << ((k + 1) % 4))); end
    end
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 4'b0100; req_data[2] = 32'h40400000;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b1000; req_data[3] = 32'h40800000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h4040 || rsp_id !== 2'd2 || rsp_flags !== 4'b0)
        begin failures++; $display("FAIL bp_hold_%0d got=v%b %h id%0d exp=v1 4040 id2", k, rsp_valid, rsp_data, rsp_id); end
      checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=0000", k, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_grant got=%b exp=1000", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'h4080)
      begin failures++; $display("FAIL bp_reload got=v%b id%0d %h exp=v1 id3 4080", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_drain();
    rsp_ready = 1'b0; en = 1'b0;
    tick();
    checks++; if (stopped !== 1'b0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL drain_enter got=s%b v%b exp=s0 v1", stopped, rsp_valid); end
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL drain_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (stopped !== 1'b0 || rsp_data !== 16'h4080) begin failures++; $display("FAIL drain_wait got=s%b %h exp=s0 4080", stopped, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    checks++; if (stopped !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL drain_stop got=s%b v%b exp=s1 v0", stopped, rsp_valid); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL stopped_ready got=%b exp=0000", req_ready); end
    en = 1'b1;
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL restart_grant got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001; req_data[0] = 32'h3F800000;
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ar_pending got=%b exp=1", rsp_valid); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || stopped !== 1'b1 || rsp_data !== 16'h0)
      begin failures++; $display("FAIL ar_clear got=v%b s%b %h exp=v0 s1 0000", rsp_valid, stopped, rsp_data); end
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL ar_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

`ifdef CVT_STICKY_FLAGS_EN
  task automatic test_sticky();
    send(3, 32'h7F7FFFFF, 16'h7F80, 4'b0100, "sticky_ovf");
    send(0, 32'h3F800001, 16'h3F80, 4'b0001, "sticky_inx");
    tick();
    checks++; if (sticky_flags !== 4'b0101) begin failures++; $display("FAIL sticky_acc got=%b exp=0101", sticky_flags); end
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    checks++; if (sticky_flags !== 4'b0000) begin failures++; $display("FAIL sticky_clear got=%b exp=0000", sticky_flags); end
  endtask
`endif

  initial begin
    test_reset();
    test_convert();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_drain();
    test_async_reset();
`ifdef CVT_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
